// File: rtl/mod_sampler_if.sv
// mod_sampler_if: read port between the modulation sampler and the modulation BRAMs.
// The sampler drives address and bank select; the memory returns read data after
// a fixed latency.
interface mod_sampler_if;
   logic [14:0] mod_idx;
   logic        mod_segment;
   logic [7:0]  mod_value;

   modport master (
      output mod_idx,
      output mod_segment,
      input  mod_value
   );

   modport slave (
      input  mod_idx,
      input  mod_segment,
      output mod_value
   );
endinterface

// File: rtl/mod_sampler.sv
// mod_sampler: walks the modulation table of the playing segment once per update
// (divided by FREQ_DIV), absorbs the BRAM read latency and presents one registered
// intensity per update. Handles immediate and end-of-cycle segment switching.
// Optional finite looping is enabled with the macro MOD_SAMPLER_LOOP_EN.
module mod_sampler #(
   parameter int NumSegment  = 2,
   parameter int ReadLatency = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          update,
   input  logic [15:0]   freq_div0,
   input  logic [15:0]   freq_div1,
   input  logic [14:0]   cycle0,
   input  logic [14:0]   cycle1,
   input  logic          req_valid,
   input  logic          req_segment,
   input  logic          req_mode,
`ifdef MOD_SAMPLER_LOOP_EN
   input  logic [15:0]   loop_rep,
`endif
   mod_sampler_if.master bram,
   output logic [7:0]    dout,
   output logic          dout_valid,
   output logic          segment_now,
   output logic          pending,
   output logic          finished
);

   // The segment select is a single bit, so only two segments can be addressed.
   if (NumSegment != 2) begin : g_cfg_check
      $error("mod_sampler supports exactly two segments");
   end

   typedef enum logic {RUN, WAIT_WRAP} state_t;

   state_t              state;
   logic [15:0]         divcnt;
   logic [14:0]         idx_q;
   logic                seg_q;
   logic                tgt_seg;
   logic                imm_req;
   logic [ReadLatency:0] strb;

   logic [15:0] div_sel;
   logic [15:0] div_last;
   logic [14:0] cyc_sel;
   logic        advance;
   logic        at_wrap;
   logic        eff_imm;
   logic        eff_sync;
   logic        eff_tgt;
   logic        do_switch;
   logic        hold_last;

`ifdef MOD_SAMPLER_LOOP_EN
   logic [15:0] rep_q;
   logic [15:0] loops_left;
   logic        fin_q;
   logic [15:0] eff_rep;

   assign eff_rep   = req_valid ? loop_rep : rep_q;
   assign hold_last = (loops_left == 16'd0);
   assign finished  = fin_q;
`else
   assign hold_last = 1'b0;
   assign finished  = 1'b0;
`endif

   assign bram.mod_idx     = idx_q;
   assign bram.mod_segment = seg_q;
   assign segment_now      = seg_q;

   // Divider and cycle length follow the playing segment live; a divider of 0 acts as 1.
   assign div_sel  = seg_q ? freq_div1 : freq_div0;
   assign div_last = (div_sel == 16'd0) ? 16'd0 : div_sel - 16'd1;
   assign cyc_sel  = seg_q ? cycle1 : cycle0;
   assign advance  = (divcnt >= div_last);
   assign at_wrap  = (idx_q >= cyc_sel);

   // A request arriving this cycle overrides whatever was latched earlier.
   assign eff_imm   = req_valid ? ~req_mode   : imm_req;
   assign eff_sync  = req_valid ? req_mode    : (state == WAIT_WRAP);
   assign eff_tgt   = req_valid ? req_segment : tgt_seg;
   assign do_switch = update & (eff_imm | (advance & at_wrap & eff_sync));

   // Segment FSM plus divider/index counters; a switch restarts the new segment at index 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RUN;
         pending    <= 1'b0;
         imm_req    <= 1'b0;
         tgt_seg    <= 1'b0;
         seg_q      <= 1'b0;
         idx_q      <= 15'd0;
         divcnt     <= 16'd0;
`ifdef MOD_SAMPLER_LOOP_EN
         rep_q      <= 16'hFFFF;
         loops_left <= 16'hFFFF;
         fin_q      <= 1'b0;
`endif
      end else begin
         if (req_valid) begin
            tgt_seg <= req_segment;
            imm_req <= ~req_mode;
            pending <= req_mode;
            state   <= req_mode ? WAIT_WRAP : RUN;
`ifdef MOD_SAMPLER_LOOP_EN
            rep_q   <= loop_rep;
`endif
         end
         if (do_switch) begin
            seg_q      <= eff_tgt;
            idx_q      <= 15'd0;
            divcnt     <= 16'd0;
            imm_req    <= 1'b0;
            pending    <= 1'b0;
            state      <= RUN;
`ifdef MOD_SAMPLER_LOOP_EN
            loops_left <= eff_rep;
            fin_q      <= 1'b0;
`endif
         end else if (update) begin
            if (!advance) begin
               divcnt <= divcnt + 16'd1;
            end else begin
               divcnt <= 16'd0;
               if (!at_wrap) begin
                  idx_q <= idx_q + 15'd1;
               end else if (hold_last) begin
                  idx_q <= cyc_sel;
`ifdef MOD_SAMPLER_LOOP_EN
                  fin_q <= 1'b1;
`endif
               end else begin
                  idx_q <= 15'd0;
`ifdef MOD_SAMPLER_LOOP_EN
                  if (loops_left != 16'hFFFF) begin
                     loops_left <= loops_left - 16'd1;
                  end
`endif
               end
            end
         end
      end
   end

   // Delay the update strobe by the BRAM latency and register the read data when it lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         strb       <= '0;
         dout       <= 8'hFF;
         dout_valid <= 1'b0;
      end else begin
         strb[0] <= update;
         for (int i = 1; i <= ReadLatency; i++) begin
            strb[i] <= strb[i-1];
         end
         dout_valid <= strb[ReadLatency];
         if (strb[ReadLatency]) begin
            dout <= bram.mod_value;
         end
      end
   end

endmodule
